// File: rtl/reg_file_nr1w_if.sv
// Register file access bundle: one write port plus READ_PORTS
// packed read ports with per-port enable and valid.
interface reg_file_nr1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_PORTS = 2
);
  logic                             we;
  logic [ADDR_WIDTH-1:0]            wAddr;
  logic [DATA_WIDTH-1:0]            wData;
  logic [READ_PORTS-1:0]            re;
  logic [READ_PORTS*ADDR_WIDTH-1:0] rAddr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rData;
  logic [READ_PORTS-1:0]            rValid;

  modport master (
    output we, wAddr, wData, re, rAddr,
    input  rData, rValid
  );

  modport slave (
    input  we, wAddr, wData, re, rAddr,
    output rData, rValid
  );
endinterface

// File: rtl/reg_file_nr1w.sv
// N-read / 1-write register file with registered reads,
// optional write-to-read bypass and optional hard-wired zero entry.
module reg_file_nr1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG0  = 0
) (
  input logic              clk,
  input logic              reset_n,
  reg_file_nr1w_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;

  assign wr_en = bus.we &&
    !(ZERO_REG0 != 0 && bus.wAddr == '0);

  // Read value seen by a port at this edge
  function automatic logic [DATA_WIDTH-1:0] value(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = mem[a];
    if (ZERO_REG0 != 0 && a == '0)
      v = '0;
    else if (BYPASS != 0 && bus.we && bus.wAddr == a)
      v = bus.wData;
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[bus.wAddr] <= bus.wData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rData  <= '0;
      bus.rValid <= '0;
    end else begin
      bus.rValid <= bus.re;
      for (int i = 0; i < READ_PORTS; i++) begin
        if (bus.re[i])
          bus.rData[i*DATA_WIDTH +: DATA_WIDTH] <=
            value(bus.rAddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_nr1w.sv
// Bench for reg_file_nr1w: default instance (bypass on) and a narrow
// 3-port instance with zero entry and bypass off, against array models.
module tb_reg_file_nr1w;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  reg_file_nr1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_PORTS(2)) b0 ();
  reg_file_nr1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_PORTS(3)) b1 ();

  reg_file_nr1w #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_PORTS(2),
    .BYPASS(1), .ZERO_REG0(0)
  ) u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));

  reg_file_nr1w #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_PORTS(3),
    .BYPASS(0), .ZERO_REG0(1)
  ) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

  // Reference state: entry contents and expected output registers
  logic [31:0] m0 [8];
  logic [7:0]  m1 [16];
  logic [31:0] e0 [2];
  logic [1:0]  ev0;
  logic [7:0]  e1 [3];
  logic [2:0]  ev1;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    for (int i = 0; i < 2; i++) e0[i] = '0;
    for (int i = 0; i < 3; i++) e1[i] = '0;
    ev0 = '0;
    ev1 = '0;
  endtask

  task automatic idle();
    b0.we = 1'b0; b0.re = '0;
    b1.we = 1'b0; b1.re = '0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [31:0] d);
    b0.we = 1'b1; b0.wAddr = a; b0.wData = d;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    b1.we = 1'b1; b1.wAddr = a; b1.wData = d;
  endtask

  task automatic rd0(input int p, input logic [2:0] a);
    b0.re[p] = 1'b1; b0.rAddr[p*3 +: 3] = a;
  endtask

  task automatic rd1(input int p, input logic [3:0] a);
    b1.re[p] = 1'b1; b1.rAddr[p*4 +: 4] = a;
  endtask

  // Advance one edge, applying the read/write rules to the model first
  task automatic tick();
    logic [2:0] a0;
    logic [3:0] a1;
    for (int i = 0; i < 2; i++) begin
      if (b0.re[i]) begin
        a0 = b0.rAddr[i*3 +: 3];
        e0[i] = (b0.we && b0.wAddr == a0) ? b0.wData : m0[a0];
      end
    end
    ev0 = b0.re;
    if (b0.we) m0[b0.wAddr] = b0.wData;
    for (int i = 0; i < 3; i++) begin
      if (b1.re[i]) begin
        a1 = b1.rAddr[i*4 +: 4];
        e1[i] = (a1 == 4'd0) ? 8'h00 : m1[a1];
      end
    end
    ev1 = b1.re;
    if (b1.we && b1.wAddr != 4'd0) m1[b1.wAddr] = b1.wData;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    b0.wAddr = '0; b0.wData = '0; b0.rAddr = '0;
    b1.wAddr = '0; b1.wData = '0; b1.rAddr = '0;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wr0(3'd1, 32'h12345678); wr1(4'd1, 8'h5A);
    tick();
    idle();
    rd0(0, 3'd1); rd0(1, 3'd1); rd1(0, 4'd1); wr0(3'd6, 32'hCAFE0000);
    tick();
    // Mid-cycle async reset with a write pending
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (b0.rData !== '0 || b0.rValid !== '0)
      $display("FAIL reset_async_p0: rData=%h rValid=%b need 0", b0.rData, b0.rValid);
    else passed++;
    total++;
    if (b1.rData !== '0 || b1.rValid !== '0)
      $display("FAIL reset_async_p1: rData=%h rValid=%b need 0", b1.rData, b1.rValid);
    else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle();
    for (int a = 0; a < 8; a++) begin
      rd0(0, 3'(a)); rd0(1, 3'(7 - a));
      tick();
      total++;
      if (b0.rData !== '0 || b0.rValid !== 2'b11)
        $display("FAIL reset_read0 a=%0d: rData=%h rValid=%b need 0/11", a, b0.rData, b0.rValid);
      else passed++;
    end
    idle();
    for (int a = 0; a < 16; a += 3) begin
      rd1(0, 4'(a)); rd1(1, 4'(a + 1)); rd1(2, 4'(a + 2));
      tick();
      total++;
      if (b1.rData !== '0 || b1.rValid !== 3'b111)
        $display("FAIL reset_read1 a=%0d: rData=%h rValid=%b need 0/111", a, b1.rData, b1.rValid);
      else passed++;
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    wr0(3'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd0(0, 3'd5);
    tick();
    total++;
    if (b0.rData[31:0] !== 32'hDEADBEEF)
      $display("FAIL wr_rd_data: got %h need DEADBEEF", b0.rData[31:0]);
    else passed++;
    total++;
    if (b0.rValid[0] !== 1'b1)
      $display("FAIL wr_rd_valid: got %b need 1", b0.rValid[0]);
    else passed++;
    idle();
    tick();
    total++;
    if (b0.rValid[0] !== 1'b0)
      $display("FAIL wr_rd_valid_drop: got %b need 0", b0.rValid[0]);
    else passed++;
    total++;
    if (b0.rData[31:0] !== 32'hDEADBEEF)
      $display("FAIL wr_rd_hold: got %h need DEADBEEF", b0.rData[31:0]);
    else passed++;
  endtask

  task automatic test_bypass();
    idle();
    wr0(3'd3, 32'h11111111); wr1(4'd3, 8'h11);
    tick();
    idle();
    wr0(3'd3, 32'h22222222); rd0(1, 3'd3);
    wr1(4'd3, 8'h22); rd1(1, 4'd3);
    tick();
    total++;
    if (b0.rData[63:32] !== 32'h22222222)
      $display("FAIL bypass_on: got %h need 22222222", b0.rData[63:32]);
    else passed++;
    total++;
    if (b1.rData[15:8] !== 8'h11)
      $display("FAIL bypass_off: got %h need 11", b1.rData[15:8]);
    else passed++;
    idle();
    rd0(0, 3'd3); rd1(0, 4'd3);
    tick();
    total++;
    if (b0.rData[31:0] !== 32'h22222222)
      $display("FAIL bypass_after0: got %h need 22222222", b0.rData[31:0]);
    else passed++;
    total++;
    if (b1.rData[7:0] !== 8'h22)
      $display("FAIL bypass_after1: got %h need 22", b1.rData[7:0]);
    else passed++;
    idle();
  endtask

  task automatic test_multi_port();
    idle();
    wr0(3'd7, 32'hA5A5A5A5);
    tick();
    idle();
    rd0(0, 3'd7); rd0(1, 3'd7); wr0(3'd2, 32'h1);
    tick();
    total++;
    if (b0.rData !== {2{32'hA5A5A5A5}} || b0.rValid !== 2'b11)
      $display("FAIL multi_port: got %h/%b need A5A5A5A5x2/11", b0.rData, b0.rValid);
    else passed++;
    idle();
    rd0(0, 3'd2);
    tick();
    total++;
    if (b0.rData[31:0] !== 32'h1 || b0.rValid !== 2'b01)
      $display("FAIL multi_port_wr: got %h/%b need 1/01", b0.rData[31:0], b0.rValid);
    else passed++;
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    wr1(4'd0, 8'hFF); rd1(0, 4'd0);
    tick();
    total++;
    if (b1.rData[7:0] !== 8'h00 || b1.rValid[0] !== 1'b1)
      $display("FAIL zero_same: got %h/%b need 00/1", b1.rData[7:0], b1.rValid[0]);
    else passed++;
    idle();
    rd1(2, 4'd0);
    tick();
    total++;
    if (b1.rData[23:16] !== 8'h00 || b1.rValid !== 3'b100)
      $display("FAIL zero_next: got %h/%b need 00/100", b1.rData[23:16], b1.rValid);
    else passed++;
    idle();
  endtask

  task automatic test_params();
    idle();
    for (int i = 0; i < 16; i++) begin
      wr1(4'(i), 8'(i));
      tick();
    end
    idle();
    rd1(0, 4'd15); rd1(1, 4'd0); rd1(2, 4'd8);
    tick();
    total++;
    if (b1.rData !== 24'h08_00_0F || b1.rValid !== 3'b111)
      $display("FAIL params_read: got %h/%b need 08000F/111", b1.rData, b1.rValid);
    else passed++;
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      b0.we = 1'($urandom); b0.wAddr = 3'($urandom); b0.wData = $urandom;
      b0.re = 2'($urandom); b0.rAddr = 6'($urandom);
      b1.we = 1'($urandom); b1.wAddr = 4'($urandom); b1.wData = 8'($urandom);
      b1.re = 3'($urandom); b1.rAddr = 12'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (b0.rData[i*32 +: 32] !== e0[i] || b0.rValid[i] !== ev0[i])
          $display("FAIL rand0 n=%0d p=%0d: got %h/%b need %h/%b", n, i,
            b0.rData[i*32 +: 32], b0.rValid[i], e0[i], ev0[i]);
        else passed++;
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (b1.rData[i*8 +: 8] !== e1[i] || b1.rValid[i] !== ev1[i])
          $display("FAIL rand1 n=%0d p=%0d: got %h/%b need %h/%b", n, i,
            b1.rData[i*8 +: 8], b1.rValid[i], e1[i], ev1[i]);
        else passed++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_multi_port();
    test_zero_reg();
    test_params();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
